// File: rtl/fios_mm_sched.sv
// fios_mm_sched: control sequencer for the EXPAND-configuration systolic FIOS Montgomery array.
// Define FIOS_SCHED_ABORT_EN to add the abort_i / aborted_o port pair.
module fios_mm_sched #(
   parameter int s        = 8,
   parameter int PE_NB    = 8,
   parameter int PE_DELAY = 8,
   parameter int RES_LAT  = 4,
   parameter int AW       = $clog2(s)
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
`ifdef FIOS_SCHED_ABORT_EN
   input  logic                 abort_i,
   output logic                 aborted_o,
`endif
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 op_rd_en_o,
   output logic [AW-1:0]        op_addr_o,
   output logic                 op_zero_o,
   output logic [PE_NB-1:0]     a_reg_en_o,
   output logic [PE_NB-1:0]     m_reg_en_o,
   output logic [2*PE_NB-1:0]   mux_A_sel_o,
   output logic [2*PE_NB-1:0]   mux_B_sel_o,
   output logic [2*PE_NB-1:0]   mux_C_sel_o,
   output logic [PE_NB-1:0]     CREG_en_o,
   output logic [7*PE_NB-1:0]   OPMODE_o,
   output logic [PE_NB-1:0]     RES_delay_en_o,
   output logic [PE_NB-1:0]     C_input_delay_en_o,
   output logic                 FIOS_input_sel_o,
   output logic                 res_we_o,
   output logic [AW-1:0]        res_addr_o
);

   localparam int T_WE0  = 1 + (PE_NB - 1) * PE_DELAY + RES_LAT;
   localparam int T_DONE = T_WE0 + s;
   localparam int T_END  = T_DONE + 1;
   localparam int TW     = $clog2(T_END + 1);

   if (PE_NB != s) begin : g_pe_nb_check
      $error("fios_mm_sched: PE_NB (%0d) must equal s (%0d)", PE_NB, s);
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic       a_en;
      logic       m_en;
      logic [1:0] sel_a;
      logic [1:0] sel_b;
      logic [1:0] sel_c;
      logic       creg_en;
      logic [6:0] opmode;
      logic       res_en;
      logic       cin_en;
   } pe_ctrl_t;

   state_t        state, state_nx;
   logic [TW-1:0] t_cnt, t_nx;
   logic          abort_req;

   logic                 busy_nx, done_nx, rd_en_nx, zero_nx, we_nx, aborted_nx;
   logic [AW-1:0]        op_addr_nx, res_addr_nx;
   logic [PE_NB-1:0]     a_en_nx, m_en_nx, creg_nx, res_en_nx, cin_nx;
   logic [2*PE_NB-1:0]   sel_a_nx, sel_b_nx, sel_c_nx;
   logic [7*PE_NB-1:0]   opmode_nx;

`ifdef FIOS_SCHED_ABORT_EN
   assign abort_req = abort_i && ((state == RUN) || (state == DRAIN));
`else
   assign abort_req = 1'b0;
`endif

   assign FIOS_input_sel_o = 1'b0;

   // PE0 control template; every other PE replays it PE_DELAY cycles later per index.
   function automatic pe_ctrl_t template_step(input int k);
      pe_ctrl_t c;
      c = '0;
      if (k == 0) begin
         c.a_en    = 1'b1;
         c.creg_en = 1'b1;
         c.opmode  = 7'h05;
      end else if (k <= s - 1) begin
         c.m_en    = (k == 1);
         c.sel_a   = 2'd1;
         c.sel_b   = 2'd1;
         c.sel_c   = 2'd1;
         c.creg_en = 1'b1;
         c.res_en  = 1'b1;
         c.cin_en  = (k != 1);
         c.opmode  = 7'h35;
      end else if (k == s) begin
         c.sel_a   = 2'd2;
         c.sel_b   = 2'd2;
         c.sel_c   = 2'd1;
         c.creg_en = 1'b1;
         c.res_en  = 1'b1;
         c.cin_en  = 1'b1;
         c.opmode  = 7'h65;
      end else begin
         c.sel_c   = 2'd2;
         c.res_en  = 1'b1;
         c.opmode  = 7'h65;
      end
      return c;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
         t_cnt <= '0;
      end else begin
         state <= state_nx;
         t_cnt <= t_nx;
      end
   end

   always_comb begin
      state_nx = state;
      t_nx     = (t_cnt == TW'(T_END)) ? t_cnt : t_cnt + 1'b1;
      unique case (state)
         IDLE: begin
            t_nx = '0;
            if (start_i) state_nx = RUN;
         end
         RUN:   if (t_cnt == TW'(s + 1)) state_nx = DRAIN;
         DRAIN: if (t_cnt == TW'(T_DONE)) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort_req) begin
         state_nx = IDLE;
         t_nx     = '0;
      end
   end

   // NOTE: outputs are decoded from next state/count and registered, so they line up with T
   // with no extra pipeline stage; every field gets a default to keep this block latch-free.
   always_comb begin
      int  tk;
      logic active;
      tk          = int'(t_nx);
      active      = (state_nx == RUN) || (state_nx == DRAIN);
      busy_nx     = (state_nx == RUN) || ((state_nx == DRAIN) && (tk != T_DONE));
      done_nx     = (state_nx == DRAIN) && (tk == T_DONE);
      aborted_nx  = abort_req;
      rd_en_nx    = 1'b0;
      zero_nx     = 1'b0;
      op_addr_nx  = '0;
      we_nx       = 1'b0;
      res_addr_nx = '0;
      a_en_nx     = '0;
      m_en_nx     = '0;
      creg_nx     = '0;
      res_en_nx   = '0;
      cin_nx      = '0;
      sel_a_nx    = '0;
      sel_b_nx    = '0;
      sel_c_nx    = '0;
      opmode_nx   = '0;

      if (state_nx == RUN) begin
         if (tk < s) begin
            rd_en_nx   = 1'b1;
            op_addr_nx = AW'(tk);
         end else begin
            zero_nx = 1'b1;
         end
      end

      for (int i = 0; i < PE_NB; i++) begin
         int       k;
         pe_ctrl_t c;
         k = tk - 1 - i * PE_DELAY;
         c = (active && (k >= 0) && (k <= s + 1)) ? template_step(k) : '0;
         a_en_nx[i]          = c.a_en;
         m_en_nx[i]          = c.m_en;
         creg_nx[i]          = c.creg_en;
         res_en_nx[i]        = c.res_en;
         cin_nx[i]           = c.cin_en;
         sel_a_nx[2*i +: 2]  = c.sel_a;
         sel_b_nx[2*i +: 2]  = c.sel_b;
         sel_c_nx[2*i +: 2]  = c.sel_c;
         opmode_nx[7*i +: 7] = c.opmode;
      end

      if (active && (tk >= T_WE0) && (tk < T_WE0 + s)) begin
         we_nx       = 1'b1;
         res_addr_nx = AW'(tk - T_WE0);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
         op_rd_en_o         <= 1'b0;
         op_addr_o          <= '0;
         op_zero_o          <= 1'b0;
         a_reg_en_o         <= '0;
         m_reg_en_o         <= '0;
         mux_A_sel_o        <= '0;
         mux_B_sel_o        <= '0;
         mux_C_sel_o        <= '0;
         CREG_en_o          <= '0;
         OPMODE_o           <= '0;
         RES_delay_en_o     <= '0;
         C_input_delay_en_o <= '0;
         res_we_o           <= 1'b0;
         res_addr_o         <= '0;
      end else begin
         busy_o             <= busy_nx;
         done_o             <= done_nx;
         op_rd_en_o         <= rd_en_nx;
         op_addr_o          <= op_addr_nx;
         op_zero_o          <= zero_nx;
         a_reg_en_o         <= a_en_nx;
         m_reg_en_o         <= m_en_nx;
         mux_A_sel_o        <= sel_a_nx;
         mux_B_sel_o        <= sel_b_nx;
         mux_C_sel_o        <= sel_c_nx;
         CREG_en_o          <= creg_nx;
         OPMODE_o           <= opmode_nx;
         RES_delay_en_o     <= res_en_nx;
         C_input_delay_en_o <= cin_nx;
         res_we_o           <= we_nx;
         res_addr_o         <= res_addr_nx;
      end
   end

`ifdef FIOS_SCHED_ABORT_EN
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) aborted_o <= 1'b0;
      else            aborted_o <= aborted_nx;
   end
`else
   logic unused_aborted;
   assign unused_aborted = aborted_nx;
`endif

endmodule

// File: tb/tb_fios_mm_sched.sv
// tb_fios_mm_sched: randomized directed-sequence bench for fios_mm_sched against a T-indexed
// reference model built straight from the schedule formulas.
module tb_fios_mm_sched;

   localparam int S        = 8;
   localparam int PE_NB    = 8;
   localparam int PE_DELAY = 8;
   localparam int RES_LAT  = 4;
   localparam int AW       = $clog2(S);
   localparam int T_WE0    = 1 + (PE_NB - 1) * PE_DELAY + RES_LAT;
   localparam int T_DONE   = T_WE0 + S;

   logic                 clk = 1'b0;
   logic                 reset_n_i, start_i;
   logic                 busy_o, done_o, op_rd_en_o, op_zero_o, fis_o, res_we_o;
   logic [AW-1:0]        op_addr_o, res_addr_o;
   logic [PE_NB-1:0]     a_reg_en_o, m_reg_en_o, creg_o, res_en_o, cin_o;
   logic [2*PE_NB-1:0]   sel_a_o, sel_b_o, sel_c_o;
   logic [7*PE_NB-1:0]   opmode_o;
`ifdef FIOS_SCHED_ABORT_EN
   logic                 abort_i, aborted_o;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fios_mm_sched #(.s(S), .PE_NB(PE_NB), .PE_DELAY(PE_DELAY), .RES_LAT(RES_LAT), .AW(AW)) dut (
      .clock_i            (clk),
      .reset_n_i          (reset_n_i),
      .start_i            (start_i),
`ifdef FIOS_SCHED_ABORT_EN
      .abort_i            (abort_i),
      .aborted_o          (aborted_o),
`endif
      .busy_o             (busy_o),
      .done_o             (done_o),
      .op_rd_en_o         (op_rd_en_o),
      .op_addr_o          (op_addr_o),
      .op_zero_o          (op_zero_o),
      .a_reg_en_o         (a_reg_en_o),
      .m_reg_en_o         (m_reg_en_o),
      .mux_A_sel_o        (sel_a_o),
      .mux_B_sel_o        (sel_b_o),
      .mux_C_sel_o        (sel_c_o),
      .CREG_en_o          (creg_o),
      .OPMODE_o           (opmode_o),
      .RES_delay_en_o     (res_en_o),
      .C_input_delay_en_o (cin_o),
      .FIOS_input_sel_o   (fis_o),
      .res_we_o           (res_we_o),
      .res_addr_o         (res_addr_o)
   );

   typedef struct packed {
      logic               busy, done, rd_en, zero, fis, we, aborted;
      logic [AW-1:0]      addr, raddr;
      logic [PE_NB-1:0]   a_en, m_en, creg, res_en, cin;
      logic [2*PE_NB-1:0] sa, sb, sc;
      logic [7*PE_NB-1:0] op;
   } ctl_t;

   // Expected outputs for a cycle T cycles into an operation (T > T_DONE: back to idle).
   function automatic ctl_t model(input int t);
      ctl_t e;
      e = '0;
      e.busy = (t >= 0) && (t < T_DONE);
      e.done = (t == T_DONE);
      if (t >= 0 && t < S) begin
         e.rd_en = 1'b1;
         e.addr  = AW'(t);
      end
      e.zero = (t == S) || (t == S + 1);
      for (int i = 0; i < PE_NB; i++) begin
         int k;
         k = t - 1 - i * PE_DELAY;
         if (k >= 0 && k <= S + 1) begin
            e.op[7*i +: 7] = (k == 0) ? 7'h05 : (k < S) ? 7'h35 : 7'h65;
            e.a_en[i]      = (k == 0);
            e.m_en[i]      = (k == 1);
            e.creg[i]      = (k <= S);
            e.res_en[i]    = (k >= 1);
            e.cin[i]       = (k >= 2) && (k <= S);
            e.sa[2*i +: 2] = (k == 0 || k == S + 1) ? 2'd0 : (k < S) ? 2'd1 : 2'd2;
            e.sb[2*i +: 2] = e.sa[2*i +: 2];
            e.sc[2*i +: 2] = (k == 0) ? 2'd0 : (k <= S) ? 2'd1 : 2'd2;
         end
      end
      if (t >= T_WE0 && t < T_WE0 + S) begin
         e.we    = 1'b1;
         e.raddr = AW'(t - T_WE0);
      end
      return e;
   endfunction

   function automatic ctl_t observe();
      ctl_t o;
      o.busy = busy_o;    o.done = done_o;    o.rd_en = op_rd_en_o; o.zero = op_zero_o;
      o.fis  = fis_o;     o.we = res_we_o;    o.addr = op_addr_o;   o.raddr = res_addr_o;
      o.a_en = a_reg_en_o; o.m_en = m_reg_en_o; o.creg = creg_o;
      o.res_en = res_en_o; o.cin = cin_o;
      o.sa = sel_a_o; o.sb = sel_b_o; o.sc = sel_c_o; o.op = opmode_o;
`ifdef FIOS_SCHED_ABORT_EN
      o.aborted = aborted_o;
`else
      o.aborted = 1'b0;
`endif
      return o;
   endfunction

   task automatic check(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s T=%0d: got 0x%0h, expected 0x%0h", tag, t, obs, exp);
      end
   endtask

   task automatic compare(input ctl_t o, input ctl_t e, input int t);
      check("busy", t, 64'(o.busy), 64'(e.busy));
      check("done", t, 64'(o.done), 64'(e.done));
      check("op_rd_en", t, 64'(o.rd_en), 64'(e.rd_en));
      check("op_addr", t, 64'(o.addr), 64'(e.addr));
      check("op_zero", t, 64'(o.zero), 64'(e.zero));
      check("fios_sel", t, 64'(o.fis), 64'(e.fis));
      check("a_reg_en", t, 64'(o.a_en), 64'(e.a_en));
      check("m_reg_en", t, 64'(o.m_en), 64'(e.m_en));
      check("creg_en", t, 64'(o.creg), 64'(e.creg));
      check("res_delay_en", t, 64'(o.res_en), 64'(e.res_en));
      check("c_in_delay_en", t, 64'(o.cin), 64'(e.cin));
      check("mux_a", t, 64'(o.sa), 64'(e.sa));
      check("mux_b", t, 64'(o.sb), 64'(e.sb));
      check("mux_c", t, 64'(o.sc), 64'(e.sc));
      check("opmode", t, 64'(o.op), 64'(e.op));
      check("res_we", t, 64'(o.we), 64'(e.we));
      check("res_addr", t, 64'(o.raddr), 64'(e.raddr));
      check("aborted", t, 64'(o.aborted), 64'(e.aborted));
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         @(negedge clk);
         compare(observe(), '0, -1);
      end
   endtask

   // Checks T=0..last_t; start_i is noise (or held high) while the operation runs.
   task automatic run_op(input bit pre_started, input bit hold_all, input int last_t);
      if (!pre_started) begin
         start_i = 1'b1;
         @(negedge clk);
      end
      for (int t = 0; t <= last_t; t++) begin
         compare(observe(), model(t), t);
         if (t == last_t) break;
         start_i = hold_all ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask

   task automatic full_op(input bit pre_started, input bit hold_all, input bit hold_next);
      run_op(pre_started, hold_all, T_DONE + 2);
      start_i = hold_next;
      @(negedge clk);
   endtask

   initial begin
      reset_n_i = 1'b0;
      start_i   = 1'b0;
`ifdef FIOS_SCHED_ABORT_EN
      abort_i   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      compare(observe(), '0, -1);
      reset_n_i = 1'b1;
      idle_gap($urandom_range(1, 4));

      // Single start pulse, random start_i noise during the run.
      full_op(1'b0, 1'b0, 1'b0);
      idle_gap($urandom_range(0, 3));

      // start_i held high: one operation, then the next begins 3 cycles after done_o.
      full_op(1'b0, 1'b1, 1'b1);
      full_op(1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-operation at T=30.
      run_op(1'b0, 1'b0, 30);
      start_i = 1'b0;
      #2 reset_n_i = 1'b0;
      #1 compare(observe(), '0, -1);
      repeat (3) begin
         @(negedge clk);
         compare(observe(), '0, -1);
      end
      reset_n_i = 1'b1;
      idle_gap(2);
      full_op(1'b0, 1'b0, 1'b0);

`ifdef FIOS_SCHED_ABORT_EN
      begin
         ctl_t e;
         abort_i = 1'b1;
         idle_gap(2);
         abort_i = 1'b0;
         run_op(1'b0, 1'b0, 40);
         start_i = 1'b0;
         abort_i = 1'b1;
         @(negedge clk);
         e = '0;
         e.aborted = 1'b1;
         compare(observe(), e, 41);
         abort_i = 1'b0;
         idle_gap(T_DONE);
         full_op(1'b0, 1'b0, 1'b0);
      end
`endif

      // Randomized back-to-back traffic.
      for (int n = 0; n < 4; n++) begin
         idle_gap($urandom_range(0, 4));
         full_op(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
